// File: rtl/video_pkg.sv
// Shared constants and the packed picture bus type for the fetch/render path.
// Optional build macro VIDEO_FETCH_UNDERRUN_EN (used by video_fetch*).
package video_pkg;

  localparam int VF_WORD_W = 16;
  localparam int VF_WORDS  = 4;
  localparam int VF_PERIOD = 16;

  typedef logic [VF_WORDS*VF_WORD_W-1:0] vf_pic_t;

endpackage

// File: rtl/video_fetch_buf.sv
// Shadow buffer: write index, same-clock merge bypass, optional zero-fill.
// VIDEO_FETCH_UNDERRUN_EN enables zero-fill and the short indication.
module video_fetch_buf
  import video_pkg::*;
#(
  parameter int WORDS = VF_WORDS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr,
  input  logic [VF_WORD_W-1:0]       wr_data,
  output logic [VF_WORD_W*WORDS-1:0] merged,
`ifdef VIDEO_FETCH_UNDERRUN_EN
  output logic                       short_o,
`endif
  output logic                       room_o
);

  localparam int CW = $clog2(WORDS + 1);

  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [WORDS-1:0][VF_WORD_W-1:0] shadow_q, shadow_d;
  logic [WORDS-1:0][VF_WORD_W-1:0] merge_w;
  logic accept;

  assign accept = wr && (wcnt_q < CW'(WORDS));

`ifdef VIDEO_FETCH_UNDERRUN_EN
  logic [CW-1:0] fill;
  assign fill    = wcnt_q + CW'(accept);
  assign short_o = fill < CW'(WORDS);
`endif

  always_comb begin
    shadow_d = shadow_q;
    wcnt_d   = wcnt_q;
    for (int k = 0; k < WORDS; k++) begin
      if (accept && CW'(k) == wcnt_q) begin
        shadow_d[k] = wr_data;
      end
    end
    if (accept) begin
      wcnt_d = wcnt_q + 1'b1;
    end
    if (clr) begin
      wcnt_d = '0;
    end
  end

  // A word arriving on the transfer clock is bypassed into its slot
  always_comb begin
    merge_w = shadow_q;
    for (int k = 0; k < WORDS; k++) begin
      if (accept && CW'(k) == wcnt_q) begin
        merge_w[k] = wr_data;
      end
`ifdef VIDEO_FETCH_UNDERRUN_EN
      else if (CW'(k) >= fill) begin
        merge_w[k] = '0;
      end
`endif
    end
  end

  assign merged = merge_w;
  assign room_o = wcnt_d < CW'(WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q   <= '0;
      shadow_q <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: rtl/video_fetch.sv
// Video fetch stage: gathers DRAM words, hands them to the renderer per period.
// VIDEO_FETCH_UNDERRUN_EN: zero-fill missing words and flag a sticky underrun.
module video_fetch
  import video_pkg::*;
#(
  parameter int WORDS  = VF_WORDS,
  parameter int PERIOD = VF_PERIOD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cend,
  input  logic                       fetch_en,
  input  logic                       line_start,
  output logic                       video_go,
  input  logic                       video_next,
  input  logic [VF_WORD_W-1:0]       video_data,
  output logic [VF_WORD_W*WORDS-1:0] pic_bits,
  output logic                       fetch_sync,
  output logic                       underrun
);

  localparam int FW = $clog2(PERIOD);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic go_q, go_d;
  logic sync_q, sync_d;
  logic [VF_WORD_W*WORDS-1:0] pic_q, pic_d, merged;
  logic run, bnd, room;

  assign run = fetch_en && !line_start;
  assign bnd = run && cend && (fcnt_q == FW'(PERIOD - 1));

`ifdef VIDEO_FETCH_UNDERRUN_EN
  logic short_w;
  logic ur_q, ur_d;
`endif

  video_fetch_buf #(
    .WORDS(WORDS)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!run || bnd),
    .wr     (run && video_next),
    .wr_data(video_data),
    .merged (merged),
`ifdef VIDEO_FETCH_UNDERRUN_EN
    .short_o(short_w),
`endif
    .room_o (room)
  );

  always_comb begin
    fcnt_d = '0;
    if (run) begin
      fcnt_d = cend ? fcnt_q + 1'b1 : fcnt_q;
    end
    go_d   = run && room;
    sync_d = bnd ? 1'b1 : (cend ? 1'b0 : sync_q);
    pic_d  = bnd ? merged : pic_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      go_q   <= 1'b0;
      sync_q <= 1'b0;
      pic_q  <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      go_q   <= go_d;
      sync_q <= sync_d;
      pic_q  <= pic_d;
    end
  end

`ifdef VIDEO_FETCH_UNDERRUN_EN
  assign ur_d = ur_q || (bnd && short_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ur_q <= 1'b0;
    end else begin
      ur_q <= ur_d;
    end
  end

  assign underrun = ur_q;
`else
  assign underrun = 1'b0;
`endif

  assign video_go   = go_q;
  assign fetch_sync = sync_q;
  assign pic_bits   = pic_q;

endmodule

// File: tb/tb_video_fetch.sv
// Directed bench for video_fetch; expectations follow VIDEO_FETCH_UNDERRUN_EN.
module tb_video_fetch;
  import video_pkg::*;

`ifdef VIDEO_FETCH_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic cend;
  logic fetch_en;
  logic line_start;
  logic video_go;
  logic video_next;
  logic [15:0] video_data;
  vf_pic_t pic_bits;
  logic fetch_sync;
  logic underrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] wd [4];

  video_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cend      (cend),
    .fetch_en  (fetch_en),
    .line_start(line_start),
    .video_go  (video_go),
    .video_next(video_next),
    .video_data(video_data),
    .pic_bits  (pic_bits),
    .fetch_sync(fetch_sync),
    .underrun  (underrun)
  );

  always #18 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic vn,
                     input logic [15:0] d, input logic ls);
    cend       = c;
    video_next = vn;
    video_data = d;
    line_start = ls;
    @(posedge clk);
    #1;
    cend       = 1'b0;
    video_next = 1'b0;
    line_start = 1'b0;
  endtask

  task automatic pixel();
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  // One full fetch period from fcnt=0; boundary on the 16th cend
  task automatic run_period(input int nw, input bit merge, input bit extra,
                            input logic [63:0] exp_pic, input logic exp_ur);
    logic vn;
    logic [15:0] d;
    for (int p = 0; p < 16; p++) begin
      cyc(1'b1, merge && p == 15, wd[3], 1'b0);
      if (p == 0) check("go_start", {63'h0, video_go}, 64'h1);
      if (p < 15) begin
        check("sync_lo", {63'h0, fetch_sync}, 64'h0);
      end else begin
        check("pic", pic_bits, exp_pic);
        check("sync_hi", {63'h0, fetch_sync}, 64'h1);
        check("go_re", {63'h0, video_go}, 64'h1);
        check("underrun", {63'h0, underrun}, {63'h0, exp_ur});
      end
      vn = (p < nw) || (extra && p == 5);
      d  = (p < nw) ? wd[p] : 16'hFFFF;
      cyc(1'b0, vn, d, 1'b0);
      if (nw == 4 && p == 3) check("go_drop", {63'h0, video_go}, 64'h0);
      cyc(1'b0, 1'b0, 16'h0, 1'b0);
      cyc(1'b0, 1'b0, 16'h0, 1'b0);
    end
    check("sync_hold", {63'h0, fetch_sync}, 64'h1);
  endtask

  initial begin
    rst_n      = 1'b0;
    cend       = 1'b0;
    fetch_en   = 1'b0;
    line_start = 1'b0;
    video_next = 1'b0;
    video_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pic", pic_bits, 64'h0);
    check("rst_sync", {63'h0, fetch_sync}, 64'h0);
    check("rst_go", {63'h0, video_go}, 64'h0);
    check("rst_ur", {63'h0, underrun}, 64'h0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 1'b0);

    fetch_en = 1'b1;
    wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_period(4, 1'b0, 1'b0, 64'h4444_3333_2222_1111, 1'b0);

    wd = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0000};
    run_period(3, 1'b0, 1'b0,
               UR_EN ? 64'h0000_CCCC_BBBB_AAAA : 64'h4444_CCCC_BBBB_AAAA,
               UR_EN);

    wd = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
    run_period(3, 1'b1, 1'b0, 64'h8888_7777_6666_5555, UR_EN);

    wd = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    run_period(4, 1'b0, 1'b1, 64'hDEF0_9ABC_5678_1234, UR_EN);

    // line_start on the boundary cend suppresses the transfer
    for (int p = 0; p < 16; p++) begin
      cyc(1'b1, 1'b0, 16'h0, p == 15);
      check("ls_sync", {63'h0, fetch_sync}, 64'h0);
      if (p == 15) begin
        check("ls_pic", pic_bits, 64'hDEF0_9ABC_5678_1234);
        check("ls_go", {63'h0, video_go}, 64'h0);
      end
      repeat (3) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    end
    repeat (6) pixel();
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    wd = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    run_period(4, 1'b0, 1'b0, 64'h0D0D_0C0C_0B0B_0A0A, UR_EN);

    // fetch_en drops at fcnt=7
    wd = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    for (int p = 0; p < 7; p++) begin
      cyc(1'b1, 1'b0, 16'h0, 1'b0);
      cyc(1'b0, p < 2, wd[p%4], 1'b0);
      cyc(1'b0, 1'b0, 16'h0, 1'b0);
      cyc(1'b0, 1'b0, 16'h0, 1'b0);
    end
    fetch_en = 1'b0;
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    check("en_go", {63'h0, video_go}, 64'h0);
    check("en_pic", pic_bits, 64'h0D0D_0C0C_0B0B_0A0A);
    repeat (20) pixel();
    check("en_sync", {63'h0, fetch_sync}, 64'h0);
    check("en_pic2", pic_bits, 64'h0D0D_0C0C_0B0B_0A0A);

    fetch_en = 1'b1;
    pixel();
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'h5A5A, 1'b0);
    check("pre_rst_go", {63'h0, video_go}, 64'h1);
    #5;
    rst_n = 1'b0;
    #2;
    check("arst_pic", pic_bits, 64'h0);
    check("arst_go", {63'h0, video_go}, 64'h0);
    check("arst_sync", {63'h0, fetch_sync}, 64'h0);
    check("arst_ur", {63'h0, underrun}, 64'h0);
    fetch_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    check("post_pic", pic_bits, 64'h0);
    check("post_go", {63'h0, video_go}, 64'h0);

    // Shadow must be zero after reset: stale slots read as zero
    fetch_en = 1'b1;
    wd = '{16'h7777, 16'h0000, 16'h0000, 16'h0000};
    run_period(1, 1'b0, 1'b0, 64'h0000_0000_0000_7777, UR_EN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
